// File: rtl/eth_phy_10g_serdes_slip_model.sv
// Link-partner bitslip model: re-presents aligned 66-bit blocks at a programmable
// bit offset and advances that offset by one bit per accepted serdes_rx_bitslip edge.
module eth_phy_10g_serdes_slip_model #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned HDR_WIDTH    = 2,
  parameter int unsigned INIT_OFFSET  = 0,
  parameter int unsigned SLIP_HOLDOFF = 4
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  bitslip,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic [6:0]            offset,
  output logic                  aligned,
  output logic                  slip_ack,
  output logic                  slip_dropped,
  output logic [7:0]            slip_count
);

  localparam int unsigned BLK_W   = DATA_WIDTH + HDR_WIDTH;
  localparam int unsigned WIN_W   = 2 * BLK_W;
  localparam int unsigned MAX_OFF = BLK_W - 1;
  localparam int unsigned HC_W    = (SLIP_HOLDOFF < 1) ? 1 : $clog2(SLIP_HOLDOFF + 1);

  // Reject unsupported geometries at elaboration time
  if (DATA_WIDTH != 64 || HDR_WIDTH != 2) begin : g_bad_width
    $error("eth_phy_10g_serdes_slip_model: only DATA_WIDTH=64, HDR_WIDTH=2 supported");
  end
  if (INIT_OFFSET > 65) begin : g_bad_offset
    $error("eth_phy_10g_serdes_slip_model: INIT_OFFSET must be 0..65");
  end

  logic [BLK_W-1:0] r0;
  logic [BLK_W-1:0] r1;
  logic [WIN_W-1:0] win_sh;
  logic [HC_W-1:0]  hc;
  logic             bs_q;
  logic             slip_edge;
  logic             slip_take;
  logic             slip_drop;
  logic [6:0]       offset_nxt;

  // Window {r1, r0}: r0 is the older block, so its bit 0 is earliest on the wire
  assign win_sh = {r1, r0} >> offset;

  // Rising-edge slip request, split into accepted and dropped by the holdoff counter
  always_comb begin
    slip_edge  = bitslip & ~bs_q;
    slip_take  = slip_edge & (hc == '0);
    slip_drop  = slip_edge & (hc != '0);
    offset_nxt = offset;
    if (slip_take) begin
      offset_nxt = (offset == 7'(MAX_OFF)) ? 7'd0 : offset + 7'd1;
    end
  end

  // Block pipeline and shifted output; the registered offset selects this edge's load
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      r0       <= '0;
      r1       <= '0;
      out_data <= '0;
      out_hdr  <= '0;
    end else begin
      r1                  <= {in_data, in_hdr};
      r0                  <= r1;
      {out_data, out_hdr} <= win_sh[BLK_W-1:0];
    end
  end

  // Slip handshake: offset, holdoff, status pulses and accepted-slip counter
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      offset       <= 7'(INIT_OFFSET);
      aligned      <= (INIT_OFFSET == 0);
      hc           <= '0;
      bs_q         <= 1'b0;
      slip_count   <= 8'd0;
      slip_ack     <= 1'b0;
      slip_dropped <= 1'b0;
    end else begin
      bs_q         <= bitslip;
      offset       <= offset_nxt;
      aligned      <= (offset_nxt == 7'd0);
      slip_ack     <= slip_take;
      slip_dropped <= slip_drop;
      if (slip_take) begin
        hc         <= HC_W'(SLIP_HOLDOFF);
        slip_count <= slip_count + 8'd1;
      end else if (!slip_drop && hc != '0) begin
        // A dropped edge freezes the holdoff; only quiet cycles count it down
        hc <= hc - HC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_eth_phy_10g_serdes_slip_model.sv
// Bench for eth_phy_10g_serdes_slip_model: directed handshake cases plus random
// traffic, checked against a serial bit-stream reference model.
module tb_eth_phy_10g_serdes_slip_model;

  localparam int unsigned INIT_OFFSET  = 0;
  localparam int unsigned SLIP_HOLDOFF = 4;
  localparam int          BLK          = 66;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic [63:0] in_data;
  logic [1:0]  in_hdr;
  logic        bitslip;
  logic [63:0] out_data;
  logic [1:0]  out_hdr;
  logic [6:0]  offset;
  logic        aligned;
  logic        slip_ack;
  logic        slip_dropped;
  logic [7:0]  slip_count;

  int errors = 0;
  int checks = 0;
  int ack_seen = 0;
  int drop_seen = 0;

  // Reference model: every bit since reset in wire order, preceded by two zero blocks
  bit          stream[$];
  int          m_base;
  int          m_off;
  int          m_hc;
  int          m_cnt;
  bit          m_bsq;
  bit          m_ack;
  bit          m_drop;
  logic [65:0] m_out;

  eth_phy_10g_serdes_slip_model #(
    .DATA_WIDTH  (64),
    .HDR_WIDTH   (2),
    .INIT_OFFSET (INIT_OFFSET),
    .SLIP_HOLDOFF(SLIP_HOLDOFF)
  ) dut (
    .rx_clk      (rx_clk),
    .rx_rst      (rx_rst),
    .in_data     (in_data),
    .in_hdr      (in_hdr),
    .bitslip     (bitslip),
    .out_data    (out_data),
    .out_hdr     (out_hdr),
    .offset      (offset),
    .aligned     (aligned),
    .slip_ack    (slip_ack),
    .slip_dropped(slip_dropped),
    .slip_count  (slip_count)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied
  task automatic model_edge();
    bit e;
    if (rx_rst) begin
      stream.delete();
      for (int i = 0; i < 2 * BLK; i++) stream.push_back(1'b0);
      m_base = 0;
      m_off  = INIT_OFFSET;
      m_hc   = 0;
      m_cnt  = 0;
      m_bsq  = 1'b0;
      m_ack  = 1'b0;
      m_drop = 1'b0;
      m_out  = '0;
    end else begin
      for (int j = 0; j < BLK; j++) m_out[j] = stream[m_base + m_off + j];
      stream.push_back(in_hdr[0]);
      stream.push_back(in_hdr[1]);
      for (int j = 0; j < 64; j++) stream.push_back(in_data[j]);
      m_base += BLK;
      e      = bitslip && !m_bsq;
      m_bsq  = bitslip;
      m_ack  = 1'b0;
      m_drop = 1'b0;
      if (e && m_hc == 0) begin
        m_off = (m_off + 1) % BLK;
        m_hc  = SLIP_HOLDOFF;
        m_cnt = (m_cnt + 1) % 256;
        m_ack = 1'b1;
      end else if (e) begin
        m_drop = 1'b1;
      end else if (m_hc > 0) begin
        m_hc--;
      end
    end
  endtask

  // One clock: update model on the edge, compare all outputs 1 time unit later
  task automatic step();
    @(posedge rx_clk);
    model_edge();
    #1;
    check_val("out_hdr", 128'(out_hdr), 128'(m_out[1:0]));
    check_val("out_data", 128'(out_data), 128'(m_out[65:2]));
    check_val("offset", 128'(offset), 128'(m_off));
    check_val("aligned", 128'(aligned), 128'(m_off == 0));
    check_val("slip_ack", 128'(slip_ack), 128'(m_ack));
    check_val("slip_dropped", 128'(slip_dropped), 128'(m_drop));
    check_val("slip_count", 128'(slip_count), 128'(m_cnt));
    ack_seen  += int'(slip_ack);
    drop_seen += int'(slip_dropped);
  endtask

  task automatic drive(input logic rst, input logic bs, input logic [1:0] h, input logic [63:0] d);
    rx_rst  = rst;
    bitslip = bs;
    in_hdr  = h;
    in_data = d;
  endtask

  task automatic drive_rand(input logic rst, input logic bs);
    drive(rst, bs, 2'($urandom_range(0, 3)), {$urandom(), $urandom()});
  endtask

  // Isolated slip: one high cycle followed by enough low cycles to clear the holdoff
  task automatic iso_slip();
    drive_rand(1'b0, 1'b1);
    step();
    for (int i = 0; i < SLIP_HOLDOFF + 1; i++) begin
      drive_rand(1'b0, 1'b0);
      step();
    end
  endtask

  initial begin
    logic [63:0] ones;
    ones = '1;

    // Reset, then a constant block: appears unshifted from the third edge
    drive(1'b1, 1'b0, 2'b01, 64'h0123456789ABCDEF);
    step();
    step();
    drive(1'b0, 1'b0, 2'b01, 64'h0123456789ABCDEF);
    for (int i = 0; i < 5; i++) step();
    check_val("t1_hdr", 128'(out_hdr), 128'(2'b01));
    check_val("t1_data", 128'(out_data), 128'(64'h0123456789ABCDEF));
    check_val("t1_aligned", 128'(aligned), 128'(1'b1));

    // Alternating blocks with one slip pulse
    ack_seen = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, (i == 3), (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 64'd0 : ones);
      step();
    end
    check_val("t2_offset", 128'(offset), 128'(7'd1));
    check_val("t2_count", 128'(slip_count), 128'(8'd1));
    check_val("t2_acks", 128'(ack_seen), 128'(1));

    // Full rotation: 66 isolated slips return to offset 0
    drive_rand(1'b1, 1'b0);
    step();
    for (int k = 0; k < BLK; k++) iso_slip();
    check_val("t3_offset", 128'(offset), 128'(7'd0));
    check_val("t3_aligned", 128'(aligned), 128'(1'b1));
    check_val("t3_count", 128'(slip_count), 128'(8'd66));

    // Two pulses two cycles apart: second falls inside holdoff
    ack_seen  = 0;
    drop_seen = 0;
    drive_rand(1'b0, 1'b1); step();
    drive_rand(1'b0, 1'b0); step();
    drive_rand(1'b0, 1'b1); step();
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b0, 1'b0);
      step();
    end
    check_val("t4_offset", 128'(offset), 128'(7'd1));
    check_val("t4_acks", 128'(ack_seen), 128'(1));
    check_val("t4_drops", 128'(drop_seen), 128'(1));

    // Reset mid-operation with offset 30 and holdoff pending
    drive_rand(1'b1, 1'b0);
    step();
    for (int k = 0; k < 29; k++) iso_slip();
    drive_rand(1'b0, 1'b1); step();
    drive_rand(1'b0, 1'b0); step();
    check_val("t5_pre_offset", 128'(offset), 128'(7'd30));
    drive_rand(1'b1, 1'b0);
    step();
    check_val("t5_offset", 128'(offset), 128'(INIT_OFFSET));
    check_val("t5_out", 128'({out_data, out_hdr}), 128'(0));
    check_val("t5_count", 128'(slip_count), 128'(8'd0));
    check_val("t5_pulses", 128'({slip_ack, slip_dropped}), 128'(2'b00));

    // bitslip held high across reset release gives exactly one accepted slip
    drive_rand(1'b1, 1'b1); step();
    for (int i = 0; i < 6; i++) begin
      drive_rand(1'b0, 1'b1);
      step();
    end
    check_val("t5b_count", 128'(slip_count), 128'(8'd1));
    check_val("t5b_offset", 128'(offset), 128'(7'd1));

    // Random traffic: level-style bitslip, occasional reset
    for (int i = 0; i < 1200; i++) begin
      drive_rand(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 2) == 0) ? ~bitslip : bitslip);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
